// File: rtl/fsm_seq_ctrl.sv
// Serialises a captured pattern into a detector (clear, shift MSB first, drain) and counts z pulses.
// Latency: start accepted at E0 -> done in cycle WIDTH+3; start is ignored while busy (no queuing), abort returns to IDLE.
// FSM_SEQ_MATCHCNT_EN: full saturating match counter; undefined: match_cnt[0] is a sticky any-match flag.
module fsm_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] pattern,
   input  logic             z_in,
   output logic             w,
   output logic             det_clr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt
);

   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

   localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic             sample;

`ifdef FSM_SEQ_MATCHCNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   logic             any_q, any_d;
`endif

   // Moore detector: z for bit k arrives one cycle late, so skip the first SHIFT cycle and take DRAIN.
   assign sample = ((state_q == SHIFT) && (bit_cnt_q != '0)) || (state_q == DRAIN);

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
`ifdef FSM_SEQ_MATCHCNT_EN
      cnt_d     = cnt_q;
      if (sample && z_in && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
`else
      any_d     = any_q;
      if (sample && z_in) begin
         any_d = 1'b1;
      end
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = CLEAR;
               sr_d      = pattern;
               bit_cnt_d = '0;
`ifdef FSM_SEQ_MATCHCNT_EN
               cnt_d     = '0;
`else
               any_d     = 1'b0;
`endif
            end
         end
         CLEAR: state_d = abort ? IDLE : SHIFT;
         SHIFT: begin
            sr_d      = {sr_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else if (bit_cnt_q == LAST_BIT) begin
               state_d = DRAIN;
            end
         end
         DRAIN:   state_d = abort ? IDLE : DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         bit_cnt_q <= '0;
`ifdef FSM_SEQ_MATCHCNT_EN
         cnt_q     <= '0;
`else
         any_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
`ifdef FSM_SEQ_MATCHCNT_EN
         cnt_q     <= cnt_d;
`else
         any_q     <= any_d;
`endif
      end
   end

   // Outputs depend on flops only, never on inputs.
   assign w       = (state_q == SHIFT) && sr_q[WIDTH-1];
   assign det_clr = (state_q == CLEAR);
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);

`ifdef FSM_SEQ_MATCHCNT_EN
   assign match_cnt = cnt_q;
`else
   assign match_cnt = CNT_W'(any_q);
`endif

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl: behavioural "010" Moore detector on one instance, a 2-bit
// counter instance with controllable z for saturation and abort; expectations queued per run.
module tb_fsm_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] pattern = 8'h00;
   logic       z_in;
   logic       z2 = 1'b1;
   logic       w, det_clr, busy, done;
   logic [3:0] match_cnt;
   logic       w2, det_clr2, busy2, done2;
   logic [1:0] match_cnt2;

   int checks = 0;
   int failures = 0;
   logic wq[$];
   int   sq[$];

`ifdef FSM_SEQ_MATCHCNT_EN
   localparam int CNT_A5 = 2;
   localparam int CNT_54 = 3;
   localparam int PARTIAL = 2;
`else
   localparam int CNT_A5 = 1;
   localparam int CNT_54 = 1;
   localparam int PARTIAL = 1;
`endif

   always #5 clk = ~clk;

   fsm_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
      .z_in(z_in), .w(w), .det_clr(det_clr), .busy(busy), .done(done), .match_cnt(match_cnt)
   );

   fsm_seq_ctrl #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
      .z_in(z2), .w(w2), .det_clr(det_clr2), .busy(busy2), .done(done2), .match_cnt(match_cnt2)
   );

   // Overlapping "010" Moore detector: 0 idle, 1 saw 0, 2 saw 01, 3 saw 010 (z=1).
   logic [1:0] det_st;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset || det_clr) begin
         det_st <= 2'd0;
      end else begin
         case (det_st)
            2'd0:    det_st <= w ? 2'd0 : 2'd1;
            2'd1:    det_st <= w ? 2'd2 : 2'd1;
            2'd2:    det_st <= w ? 2'd0 : 2'd3;
            default: det_st <= w ? 2'd2 : 2'd1;
         endcase
      end
   end
   assign z_in = (det_st == 2'd3);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected 2-bit counter value in cycle c with z tied high (samples land in cycles 3..10).
   function automatic int sat_exp(input int c);
`ifdef FSM_SEQ_MATCHCNT_EN
      if (c <= 3) return 0;
      return (c - 3 > 3) ? 3 : c - 3;
`else
      return (c <= 3) ? 0 : 1;
`endif
   endfunction

   task automatic do_start(input logic [7:0] p);
      pattern = p;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run(input logic [7:0] p, input logic pulse, input int exp_cnt);
      logic b;
      int e;
      for (int i = 7; i >= 0; i--) wq.push_back(p[i]);
      for (int c = 1; c <= 11; c++) sq.push_back(sat_exp(c));
      do_start(p);
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) begin
            tick();
            start = 1'b0;
         end
         b = (c >= 2 && c <= 9) ? wq.pop_front() : 1'b0;
         check("w", 32'(w), 32'(b));
         check("det_clr", 32'(det_clr), 32'(c == 1));
         check("done", 32'(done), 32'(c == 11));
         check("busy", 32'(busy), 32'(c <= 11));
         if (c <= 11) begin
            e = sq.pop_front();
            check("sat_cnt", 32'(match_cnt2), 32'(e));
         end
         if (c == 11) check("match_cnt", 32'(match_cnt), 32'(exp_cnt));
         if (pulse && (c == 4 || c == 11)) begin
            start = 1'b1;
            pattern = ~p;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) tick();
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      tick();
      check("rst_w", 32'(w), 32'd0);
      check("rst_det_clr", 32'(det_clr), 32'd0);
      check("rst_busy_rel", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cnt", 32'(match_cnt), 32'd0);

      run(8'hA5, 1'b0, CNT_A5);
      run(8'b0101_0100, 1'b0, CNT_54);
      run(8'hA5, 1'b1, CNT_A5);

      // Abort in cycle 5 with z low in that cycle: partial count reflects cycles 3 and 4 only.
      do_start(8'hFF);
      for (int c = 2; c <= 5; c++) tick();
      check("abort_pre_cnt", 32'(match_cnt2), 32'(sat_exp(5)));
      check("abort_pre_w", 32'(w), 32'd1);
      abort = 1'b1;
      z2 = 1'b0;
      tick();
      abort = 1'b0;
      z2 = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_w", 32'(w), 32'd0);
      check("abort_det_clr", 32'(det_clr), 32'd0);
      check("abort_cnt", 32'(match_cnt2), 32'(PARTIAL));
      for (int i = 0; i < 10; i++) begin
         tick();
         check("abort_no_done", 32'(done), 32'd0);
         check("abort_idle", 32'(busy), 32'd0);
         check("abort_hold", 32'(match_cnt2), 32'(PARTIAL));
      end

      // Asynchronous reset in cycle 6 of a run, then a clean run.
      do_start(8'hA5);
      for (int c = 2; c <= 6; c++) tick();
      check("mid_busy_pre", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("mid_w", 32'(w), 32'd0);
      check("mid_det_clr", 32'(det_clr), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_cnt", 32'(match_cnt), 32'd0);
      check("mid_cnt_sat", 32'(match_cnt2), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      run(8'b0101_0100, 1'b0, CNT_54);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fsm_seq_ctrl.md
# fsm_seq_ctrl

Sequencing controller for the lab's serial-input state-machine detectors. Captures a parallel test pattern, clears the detector, feeds the pattern one bit per clock into the detector's serial input `w`, and counts detector output `z` pulses. Sits between a host or bench stimulus source and one detector instance, with a start/busy/done handshake toward the host.

## Interface

- `WIDTH`, 8, pattern length in bits; must be ≥ 2.
- `CNT_W`, 4, width of the match counter.

- `clk`  in  1  rising-edge clock shared with the detector.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to run one pattern; sampled only in IDLE.
- `abort`  in  1  cancel the run in progress; sampled in CLEAR, SHIFT and DRAIN.
- `pattern`  in  WIDTH  pattern to serialise; captured in the accept cycle.
- `z_in`  in  1  detector output `z`.
- `w`  out  1  serial bit to the detector, MSB first.
- `det_clr`  out  1  active-high synchronous clear to the detector.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  single-cycle completion pulse.
- `match_cnt`  out  CNT_W  number of cycles in which `z_in` was sampled high in the last run.

## Operation

- States are IDLE, CLEAR, SHIFT, DRAIN and DONE, with registered state.
- IDLE: `busy`=0. If `start`=1, go to CLEAR, load `pattern` into the shift register, zero `match_cnt`, and zero the bit counter.
- CLEAR: `det_clr`=1 and `w`=0 for exactly one cycle, then go to SHIFT.
- SHIFT: `w` = shift register MSB. Each cycle the register shifts left (zero fill) and the bit counter increments. After WIDTH cycles, go to DRAIN.
- DRAIN: `w`=0 for one cycle, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. `start` is ignored in DONE.
- Sampling `z_in`:
  - The detector is Moore, so `z` for bit k is visible the cycle after bit k is presented.
  - `z_in` is sampled in SHIFT cycles 2..WIDTH and in DRAIN, which is exactly WIDTH samples.
  - `z_in` is ignored in IDLE, CLEAR, the first SHIFT cycle and DONE.
- Counter arithmetic: `match_cnt` increments by 1 per sampled high and saturates at 2^CNT_W−1 with no wrap.
- `match_cnt` holds its value after DONE until the next accepted `start`.
- `start` while `busy`=1 is ignored, with no queuing.
- `abort`=1 in CLEAR, SHIFT or DRAIN: go to IDLE on the next edge.
  - No `done` pulse.
  - `match_cnt` keeps its partial value.
  - `det_clr`=0 and `w`=0 from the next cycle.
- If `abort` and the final SHIFT→DRAIN transition coincide, `abort` wins.
- Asserting `reset` (low) at any time immediately forces:
  - state=IDLE
  - `w`=0, `det_clr`=0, `busy`=0, `done`=0
  - `match_cnt`=0, shift register=0
- `w`, `det_clr` and `done` are decoded from registered state and shift register only, never from inputs, so they are glitch-free.

## Timing

- Reset values: all outputs 0.
- Start accepted at edge E0:
  - CLEAR is cycle 1.
  - SHIFT is cycles 2..WIDTH+1.
  - DRAIN is cycle WIDTH+2.
  - DONE (`done`=1) is cycle WIDTH+3.
  - IDLE from cycle WIDTH+4.
- Total latency from start to `done` is WIDTH+3 cycles. The earliest next accepted `start` is in cycle WIDTH+4.
- `busy` rises in cycle 1 and falls in cycle WIDTH+4.
- `match_cnt` is final and stable in the DONE cycle.

## Configuration

- `FSM_SEQ_MATCHCNT_EN` defined: full saturating CNT_W-bit counter as described above.
- `FSM_SEQ_MATCHCNT_EN` undefined:
  - `match_cnt[0]` is a sticky "any match" flag: set on the first sampled high and cleared at accept.
  - `match_cnt[CNT_W-1:1]` is tied to 0.
  - No counter logic is synthesised.
- Port list is identical in both builds.

## Test plan

- Reset and sequencing:
  - Hold `reset`=0 for 3 cycles, then release → all outputs 0.
  - Start with `pattern`=8'hA5 → `det_clr`=1 in cycle 1 only; `w` = 1,0,1,0,0,1,0,1 in cycles 2..9; `done`=1 in cycle 11 only.
- Match counting:
  - `z_in` driven by a behavioural overlapping "010" detector, `pattern`=8'b0101_0100 → `match_cnt`=3 in the DONE cycle (counter enabled); `match_cnt`=1 with the macro undefined.
- Saturation:
  - CNT_W=2, `z_in` tied to 1, WIDTH=8 → 8 samples; `match_cnt` reads 1,2,3,3,…, final value 3.
- Start while busy:
  - Pulse `start` in cycles 4 and 11 with a different pattern → ignored; the `w` stream is unchanged; a single `done` in cycle 11.
- Abort and reset mid-run:
  - `abort`=1 in cycle 5 → IDLE at cycle 6, no `done`, partial `match_cnt` held.
  - Separately, `reset` low in cycle 6 of a run → immediate all-zero outputs; a new `start` afterwards runs normally.
